// File: rtl/jpeg_mcu_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_mcu_pkg
// Shared definitions for the JPEG MCU buffer:
//   - sampling-mode encodings (4:4:4, 4:2:2, 4:2:0, reserved)
//   - chroma block identifiers
//   - last pixel address of an MCU for each mode
//   - index helpers mapping block/pixel addresses onto RAM locations
// Package only, no ports.
// ---------------------------------------------------------------------------
package jpeg_mcu_pkg;

    typedef enum logic [1:0] {
        MODE_444  = 2'd0,
        MODE_422  = 2'd1,
        MODE_420  = 2'd2,
        MODE_RSVD = 2'd3
    } mcu_mode_e;

    localparam logic [2:0] BLK_CB = 3'd4;
    localparam logic [2:0] BLK_CR = 3'd5;

    localparam logic [7:0] LAST_ADDR_444 = 8'd63;
    localparam logic [7:0] LAST_ADDR_422 = 8'd127;
    localparam logic [7:0] LAST_ADDR_420 = 8'd255;

    // The reserved encoding behaves exactly like 4:4:4.
    function automatic mcu_mode_e decodeMode(input logic [1:0] mode);
        mcu_mode_e result;
        case (mode)
            2'd1:    result = MODE_422;
            2'd2:    result = MODE_420;
            default: result = MODE_444;
        endcase
        return result;
    endfunction

    // Chroma blocks are always legal; the number of legal luma blocks
    // grows with the horizontal/vertical subsampling of the mode.
    function automatic logic blockLegal(input mcu_mode_e mode, input logic [2:0] block);
        logic result;
        if (block == BLK_CB || block == BLK_CR) begin
            result = 1'b1;
        end else begin
            case (mode)
                MODE_422: result = (block < 3'd2);
                MODE_420: result = (block < 3'd4);
                default:  result = (block == 3'd0);
            endcase
        end
        return result;
    endfunction

    // Luma blocks tile a 16x16 plane per bank: block bit 0 selects the
    // right half, block bit 1 the lower half (lower half only in 4:2:0).
    function automatic logic [7:0] yWriteIndex(input mcu_mode_e mode,
                                               input logic [1:0] block,
                                               input logic [5:0] addr);
        logic rowHi;
        logic colHi;
        rowHi = (mode == MODE_420) & block[1];
        colHi = ((mode == MODE_422) || (mode == MODE_420)) & block[0];
        return {rowHi, addr[5:3], colHi, addr[2:0]};
    endfunction

    // Pixel raster address to {row[3:0], col[3:0]} in the luma plane.
    // Address bits above the MCU size are dropped.
    function automatic logic [7:0] yReadIndex(input mcu_mode_e mode, input logic [7:0] addr);
        logic [7:0] result;
        case (mode)
            MODE_422: result = {1'b0, addr[6:4], addr[3:0]};
            MODE_420: result = addr;
            default:  result = {1'b0, addr[5:3], 1'b0, addr[2:0]};
        endcase
        return result;
    endfunction

    // Chroma location derived from the luma {row, col}: halving the column
    // for 4:2:2/4:2:0 and the row for 4:2:0 replicates each chroma sample.
    function automatic logic [5:0] cReadIndex(input mcu_mode_e mode, input logic [7:0] yIdx);
        logic [5:0] result;
        case (mode)
            MODE_422: result = {yIdx[6:4], yIdx[3:1]};
            MODE_420: result = {yIdx[7:5], yIdx[3:1]};
            default:  result = {yIdx[6:4], yIdx[2:0]};
        endcase
        return result;
    endfunction

    function automatic logic isLastAddr(input mcu_mode_e mode, input logic [7:0] addr);
        logic result;
        case (mode)
            MODE_422: result = ({1'b0, addr[6:0]} == LAST_ADDR_422);
            MODE_420: result = (addr == LAST_ADDR_420);
            default:  result = ({2'b00, addr[5:0]} == LAST_ADDR_444);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/jpeg_sdp_ram.sv
// ---------------------------------------------------------------------------
// jpeg_sdp_ram
// Simple dual-port RAM with one write port and one registered read port.
// Read data appears one cycle after i_rdEnable and holds otherwise.
// Ports:
//   i_clk        clock, rising edge
//   i_clear      synchronous clear of the read data register (not the array)
//   i_wrEnable   write strobe
//   i_wrAddress  write address
//   i_wrData     write data
//   i_rdEnable   read strobe
//   i_rdAddress  read address
//   o_rdData     registered read data
// ---------------------------------------------------------------------------
module jpeg_sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_wrEnable,
    input  logic [ADDR_W-1:0] i_wrAddress,
    input  logic [WIDTH-1:0]  i_wrData,
    input  logic              i_rdEnable,
    input  logic [ADDR_W-1:0] i_rdAddress,
    output logic [WIDTH-1:0]  o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    // Storage array: no reset so that it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wrEnable) begin
            r_mem[i_wrAddress] <= i_wrData;
        end
    end

    // Read register: cleared on flush, otherwise only updated by a read so
    // the last returned sample stays on the output.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_rdData <= '0;
        end else if (i_rdEnable) begin
            r_rdData <= r_mem[i_rdAddress];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/jpeg_mcu_buffer.sv
// ---------------------------------------------------------------------------
// jpeg_mcu_buffer
// Multi-bank MCU buffer between the IDCT and the YCbCr-to-RGB converter.
// Decoded 8x8 blocks of one MCU are written into a free bank; up to BANKS
// complete MCUs are queued. Reads return one pixel per request with the
// chroma upsampled by replication (4:4:4, 4:2:2 and 4:2:0).
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   DataInit                 synchronous flush (RAM contents kept)
//   Mode                     sampling mode, changed only while empty
//   DataInEnable/Block/Address/DataIn/DataInLast   block sample writes
//   DataInReady              a bank is free
//   DataOutEnable            a complete MCU is queued
//   DataOutAddress/DataOutRead                     pixel read request
//   DataOutValid, DataOutY/Cb/Cr                   pixel returned next cycle
//   DataInError              sticky flag for rejected writes
// ---------------------------------------------------------------------------
module jpeg_mcu_buffer
    import jpeg_mcu_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int BANKS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DataInit,
    input  logic [1:0]        Mode,
    input  logic              DataInEnable,
    input  logic [2:0]        DataInBlock,
    input  logic [5:0]        DataInAddress,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataInLast,
    output logic              DataInReady,
    output logic              DataOutEnable,
    input  logic [7:0]        DataOutAddress,
    input  logic              DataOutRead,
    output logic              DataOutValid,
    output logic [DATA_W-1:0] DataOutY,
    output logic [DATA_W-1:0] DataOutCb,
    output logic [DATA_W-1:0] DataOutCr,
    output logic              DataInError
);

    localparam int PW      = $clog2(BANKS);
    localparam int CW      = PW + 1;
    localparam int Y_DEPTH = 256 * BANKS;
    localparam int C_DEPTH = 64 * BANKS;
    localparam int Y_AW    = PW + 8;
    localparam int C_AW    = PW + 6;

    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_count;
    logic              r_error;
    logic              r_valid;

    mcu_mode_e         w_mode;
    logic              w_flush;
    logic              w_ready;
    logic              w_enable;
    logic              w_blockLegal;
    logic              w_wrAccept;
    logic              w_wrReject;
    logic              w_commit;
    logic              w_isY;
    logic              w_isCb;
    logic              w_isCr;
    logic              w_rdAccept;
    logic              w_release;
    logic [7:0]        w_yWrIdx;
    logic [7:0]        w_yRdIdx;
    logic [5:0]        w_cRdIdx;
    logic [Y_AW-1:0]   w_yWrAddr;
    logic [Y_AW-1:0]   w_yRdAddr;
    logic [C_AW-1:0]   w_cWrAddr;
    logic [C_AW-1:0]   w_cRdAddr;
    logic [DATA_W-1:0] w_yData;
    logic [DATA_W-1:0] w_cbData;
    logic [DATA_W-1:0] w_crData;

    assign w_mode   = decodeMode(Mode);
    assign w_flush  = !rst || DataInit;
    assign w_ready  = (r_count < CW'(BANKS));
    assign w_enable = (r_count != '0);

    // Write side. A write is only accepted into a free bank and for a block
    // that exists in the current mode; anything else is dropped and flagged.
    // A flush suppresses every other input including RAM writes.
    assign w_blockLegal = blockLegal(w_mode, DataInBlock);
    assign w_wrAccept   = !w_flush && DataInEnable && w_ready && w_blockLegal;
    assign w_wrReject   = DataInEnable && !w_wrAccept;
    assign w_commit     = w_wrAccept && DataInLast;
    assign w_isY        = !DataInBlock[2];
    assign w_isCb       = (DataInBlock == BLK_CB);
    assign w_isCr       = (DataInBlock == BLK_CR);
    assign w_yWrIdx     = yWriteIndex(w_mode, DataInBlock[1:0], DataInAddress);
    assign w_yWrAddr    = {r_wp, w_yWrIdx};
    assign w_cWrAddr    = {r_wp, DataInAddress};

    // Read side. Reads of an empty buffer never touch the RAMs. Reaching the
    // mode's last pixel frees the bank; the data already being fetched from
    // it in this cycle is unaffected because the RAM read is registered.
    assign w_rdAccept = !w_flush && DataOutRead && w_enable;
    assign w_release  = w_rdAccept && isLastAddr(w_mode, DataOutAddress);
    assign w_yRdIdx   = yReadIndex(w_mode, DataOutAddress);
    assign w_cRdIdx   = cReadIndex(w_mode, w_yRdIdx);
    assign w_yRdAddr  = {r_rp, w_yRdIdx};
    assign w_cRdAddr  = {r_rp, w_cRdIdx};

    // Bank bookkeeping: write/read pointers wrap naturally because BANKS is
    // a power of two; a commit and a release in the same cycle cancel out in
    // the occupancy count while both pointers still move.
    always_ff @(posedge clk) begin
        if (!rst || DataInit) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_error <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_commit) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_release) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({w_commit, w_release})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_wrReject) begin
                r_error <= 1'b1;
            end
            r_valid <= w_rdAccept;
        end
    end

    jpeg_sdp_ram #(
        .WIDTH  (DATA_W),
        .DEPTH  (Y_DEPTH),
        .ADDR_W (Y_AW)
    ) u_yRam (
        .i_clk       (clk),
        .i_clear     (w_flush),
        .i_wrEnable  (w_wrAccept && w_isY),
        .i_wrAddress (w_yWrAddr),
        .i_wrData    (DataIn),
        .i_rdEnable  (w_rdAccept),
        .i_rdAddress (w_yRdAddr),
        .o_rdData    (w_yData)
    );

    jpeg_sdp_ram #(
        .WIDTH  (DATA_W),
        .DEPTH  (C_DEPTH),
        .ADDR_W (C_AW)
    ) u_cbRam (
        .i_clk       (clk),
        .i_clear     (w_flush),
        .i_wrEnable  (w_wrAccept && w_isCb),
        .i_wrAddress (w_cWrAddr),
        .i_wrData    (DataIn),
        .i_rdEnable  (w_rdAccept),
        .i_rdAddress (w_cRdAddr),
        .o_rdData    (w_cbData)
    );

    jpeg_sdp_ram #(
        .WIDTH  (DATA_W),
        .DEPTH  (C_DEPTH),
        .ADDR_W (C_AW)
    ) u_crRam (
        .i_clk       (clk),
        .i_clear     (w_flush),
        .i_wrEnable  (w_wrAccept && w_isCr),
        .i_wrAddress (w_cWrAddr),
        .i_wrData    (DataIn),
        .i_rdEnable  (w_rdAccept),
        .i_rdAddress (w_cRdAddr),
        .o_rdData    (w_crData)
    );

    assign DataInReady   = w_ready;
    assign DataOutEnable = w_enable;
    assign DataOutValid  = r_valid;
    assign DataOutY      = w_yData;
    assign DataOutCb     = w_cbData;
    assign DataOutCr     = w_crData;
    assign DataInError   = r_error;

endmodule
